memchr_reader: RTL and testbench

- Read-side counterpart to the memset writer. Scans up to n bytes of the 32x8 single-port RAM, starting at byte address m, for the first byte equal to c[7:0].
- Reaches the RAM through the existing memory controller, treating it as read-only.
- Uses the same start/finish/return_val handshake as the other LLVM-style accelerator blocks.
- Pipelined: issues one read address per cycle and compares returned data one cycle later.

---
 rtl/memchr_reader_if.sv | 35 +++
 rtl/memchr_reader.sv | 140 ++++++++++++++
 tb/tb_memchr_reader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/memchr_reader_if.sv
// memchr_reader_if: groups the accelerator handshake and the memory
// controller port of memchr_reader.
//   start, m, c, n              launch request and scan arguments
//   finish, found, return_val   result handshake
//   memory_controller_*         read-only path into the 32x8 RAM controller
// Modport master is the accelerator's view. Modport slave is the view of the
// environment: the host and the memory controller.
interface memchr_reader_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] m;
    logic [31:0]       c;
    logic [31:0]       n;
    logic              finish;
    logic              found;
    logic [ADDR_W-1:0] return_val;
    logic [ADDR_W-1:0] memory_controller_address;
    logic              memory_controller_write_enable;
    logic [DATA_W-1:0] memory_controller_in;
    logic [DATA_W-1:0] memory_controller_out;

    modport master (
        input  start, m, c, n, memory_controller_out,
        output finish, found, return_val, memory_controller_address,
               memory_controller_write_enable, memory_controller_in
    );

    modport slave (
        output start, m, c, n, memory_controller_out,
        input  finish, found, return_val, memory_controller_address,
               memory_controller_write_enable, memory_controller_in
    );
endinterface

// File: rtl/memchr_reader.sv
// memchr_reader: scans up to n bytes of RAM, starting at byte address m, for
// the first byte equal to c[7:0].
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    memchr_reader_if.master. It carries the start/finish/return_val
//          handshake, the found flag, and the read-only memory controller
//          port. Write enable and write data are held at 0.
// Pipelined: one read address is issued per cycle. Its data is compared in
// the cycle after the RAM registers that address.
module memchr_reader #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    memchr_reader_if.master bus
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] m_q, m_d;
    logic [7:0]        c_q, c_d;
    logic [31:0]       n_q, n_d;
    logic [31:0]       i_q, i_d;
    logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
    logic              pipe_valid_q, pipe_valid_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [ADDR_W-1:0] issue_addr;
    logic              hit;

    // Address on the bus this cycle. The sum wraps modulo 2^ADDR_W.
    assign issue_addr = m_q + ADDR_W'(i_q);
    // Data for pipe_addr_q is present this cycle.
    assign hit = pipe_valid_q && (bus.memory_controller_out[7:0] == c_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            m_q          <= '0;
            c_q          <= '0;
            n_q          <= '0;
            i_q          <= '0;
            pipe_addr_q  <= '0;
            pipe_valid_q <= 1'b0;
            found_q      <= 1'b0;
            ret_q        <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            c_q          <= c_d;
            n_q          <= n_d;
            i_q          <= i_d;
            pipe_addr_q  <= pipe_addr_d;
            pipe_valid_q <= pipe_valid_d;
            found_q      <= found_d;
            ret_q        <= ret_d;
            addr_q       <= addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        c_d          = c_q;
        n_d          = n_q;
        i_d          = i_q;
        pipe_addr_d  = pipe_addr_q;
        pipe_valid_d = pipe_valid_q;
        found_d      = found_q;
        ret_d        = ret_q;
        addr_d       = addr_q;

        case (state_q)
            IDLE: begin
                pipe_valid_d = 1'b0;
                if (bus.start) begin
                    m_d     = bus.m;
                    c_d     = bus.c[7:0];
                    n_d     = bus.n;
                    i_d     = '0;
                    found_d = 1'b0;
                    ret_d   = '0;
                    if (bus.n == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = bus.m;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                pipe_addr_d  = issue_addr;
                pipe_valid_d = 1'b1;
                i_d          = i_q + 32'd1;
                if (hit) begin
                    // The read issued this cycle is abandoned.
                    found_d      = 1'b1;
                    ret_d        = pipe_addr_q;
                    pipe_valid_d = 1'b0;
                    state_d      = DONE;
                end else if (i_q + 32'd1 == n_q) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = issue_addr + ADDR_W'(1);
                end
            end
            DRAIN: begin
                pipe_valid_d = 1'b0;
                if (hit) begin
                    found_d = 1'b1;
                    ret_d   = pipe_addr_q;
                end else begin
                    found_d = 1'b0;
                    ret_d   = '0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.finish                         = (state_q == DONE);
    assign bus.found                          = found_q;
    assign bus.return_val                     = ret_q;
    assign bus.memory_controller_address      = addr_q;
    assign bus.memory_controller_write_enable = 1'b0;
    assign bus.memory_controller_in           = '0;

endmodule

// File: tb/tb_memchr_reader.sv
// tb_memchr_reader: directed testbench for memchr_reader.
// Contains a 32x8 RAM model that registers the read address and returns its
// data one cycle later. Inputs are driven on the falling edge, and outputs are
// sampled on the falling edge. Cycle 0 is the cycle in which start is sampled.
module tb_memchr_reader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memchr_reader_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memchr_reader #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] ram [32];
    logic [7:0] rd_data = 8'h00;
    always @(posedge clk) rd_data <= ram[bus.memory_controller_address[4:0]];
    assign bus.memory_controller_out = {24'h0, rd_data};

    int we_bad = 0;
    always @(posedge clk)
        if (bus.memory_controller_write_enable !== 1'b0 || bus.memory_controller_in !== 32'h0)
            we_bad++;

    int errors = 0;
    int checks = 0;
    logic [31:0] addr_log [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launches one scan. If pulse_cyc is nonzero, a second start with
    // unrelated arguments is pulsed at that cycle. That start must be ignored.
    task automatic run_scan(input string tag, input logic [31:0] mm, input logic [31:0] cc,
                            input logic [31:0] nn, input logic exp_found,
                            input logic [31:0] exp_ret, input int exp_cyc, input int pulse_cyc);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.m = mm; bus.c = cc; bus.n = nn;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (bus.finish !== 1'b1 && cyc < 60) begin
            addr_log[cyc] = bus.memory_controller_address;
            @(negedge clk);
            cyc++;
            if (cyc == pulse_cyc) begin
                bus.start = 1'b1; bus.m = 32'd5; bus.c = 32'hAA; bus.n = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({tag, " finish_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " found"}, {31'h0, bus.found}, {31'h0, exp_found});
        check({tag, " return_val"}, bus.return_val, exp_ret);
        @(negedge clk);
        check({tag, " finish_pulse"}, {31'h0, bus.finish}, 32'h0);
        check({tag, " found_held"}, {31'h0, bus.found}, {31'h0, exp_found});
    endtask

    initial begin
        logic [31:0] addr_before;
        int stray;
        for (int i = 0; i < 32; i++) ram[i] = 8'h10 + 8'(i);
        bus.start = 1'b0; bus.m = '0; bus.c = '0; bus.n = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset finish", {31'h0, bus.finish}, 32'h0);
        check("reset found", {31'h0, bus.found}, 32'h0);
        check("reset return_val", bus.return_val, 32'h0);
        check("reset address", bus.memory_controller_address, 32'h0);
        reset = 1'b0;

        run_scan("match_k3", 32'd0, 32'h13, 32'd8, 1'b1, 32'd3, 6, 0);

        run_scan("nomatch", 32'd0, 32'h55, 32'd8, 1'b0, 32'd0, 10, 0);
        for (int i = 1; i <= 8; i++)
            check($sformatf("nomatch addr_seq[%0d]", i), addr_log[i], 32'(i - 1));

        run_scan("match_k3b", 32'd0, 32'h13, 32'd8, 1'b1, 32'd3, 6, 0);
        addr_before = bus.memory_controller_address;
        run_scan("n0", 32'd9, 32'h12, 32'd0, 1'b0, 32'd0, 1, 0);
        check("n0 address_unchanged", bus.memory_controller_address, addr_before);

        ram[5] = 8'hAA;
        run_scan("n1", 32'd5, 32'hAA, 32'd1, 1'b1, 32'd5, 3, 0);
        ram[5] = 8'h15;

        ram[2] = 8'h7E; ram[6] = 8'h7E;
        run_scan("dup", 32'd0, 32'h1237E, 32'd8, 1'b1, 32'd2, 5, 0);
        ram[2] = 8'h12; ram[6] = 8'h16;

        ram[1] = 8'h99;
        run_scan("wrap", 32'hFFFF_FFFE, 32'h99, 32'd4, 1'b1, 32'd1, 6, 0);
        ram[1] = 8'h11;

        run_scan("last", 32'd0, 32'h17, 32'd8, 1'b1, 32'd7, 10, 0);

        run_scan("start_ignored", 32'd0, 32'h13, 32'd8, 1'b1, 32'd3, 6, 2);

        // Reset arrives in the middle of a scan, while the bus shows address 2 in cycle 3.
        @(negedge clk);
        bus.start = 1'b1; bus.m = 32'd0; bus.c = 32'h17; bus.n = 32'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("midscan address_c3", bus.memory_controller_address, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("midreset finish", {31'h0, bus.finish}, 32'h0);
        check("midreset found", {31'h0, bus.found}, 32'h0);
        check("midreset return_val", bus.return_val, 32'h0);
        check("midreset address", bus.memory_controller_address, 32'h0);
        reset = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.finish === 1'b1) stray++;
        end
        check("midreset no_stray_finish", 32'(stray), 32'h0);
        run_scan("after_reset", 32'd0, 32'h13, 32'd8, 1'b1, 32'd3, 6, 0);

        check("write_enable_never", 32'(we_bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
